// File: rtl/idma_axi_write_pkg.sv
// Shared types and defaults for the iDMA AXI4 write task.
// Only the AXI fields this task forwards are modelled in the channel structs.
package idma_axi_write_pkg;

    localparam int unsigned DefaultStrbWidth      = 16;
    localparam int unsigned DefaultMaxOutstanding = 8;
    localparam int unsigned AddrWidth             = 32;
    localparam int unsigned IdWidth               = 4;
    localparam int unsigned UserWidth             = 2;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } axi_resp_e;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
    } axi_aw_chan_t;

    typedef struct packed {
        axi_aw_chan_t aw_chan;
    } axi_aw_meta_t;

    // AW meta request as handed over by the burst splitter.
    typedef struct packed {
        axi_aw_meta_t axi;
    } aw_chan_t;

    // offset/tailer are byte positions within a beat; only values below StrbWidth are meaningful.
    typedef struct packed {
        logic [7:0] offset;
        logic [7:0] tailer;
        logic [7:0] num_beats;
        logic       is_single;
    } w_dp_req_t;

    typedef struct packed {
        axi_resp_e            resp;
        logic [UserWidth-1:0] user;
    } w_dp_rsp_t;

endpackage

// File: rtl/idma_axi_write_if.sv
// AXI4 write manager port of the iDMA write task (AW, W, B plus the tied-off read request).
interface idma_axi_write_if
    import idma_axi_write_pkg::*;
#(
    parameter int unsigned StrbWidth = DefaultStrbWidth
) ();

    axi_aw_chan_t              aw;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [StrbWidth-1:0][7:0] w_data;
    logic [StrbWidth-1:0]      w_strb;
    logic                      w_last;
    logic                      w_valid;
    logic                      w_ready;

    axi_resp_e                 b_resp;
    logic [UserWidth-1:0]      b_user;
    logic                      b_valid;
    logic                      b_ready;

    axi_aw_chan_t              ar;
    logic                      ar_valid;
    logic                      r_ready;

    modport master (
        output aw, aw_valid, w_data, w_strb, w_last, w_valid, b_ready, ar, ar_valid, r_ready,
        input  aw_ready, w_ready, b_resp, b_user, b_valid
    );

    modport slave (
        input  aw, aw_valid, w_data, w_strb, w_last, w_valid, b_ready, ar, ar_valid, r_ready,
        output aw_ready, w_ready, b_resp, b_user, b_valid
    );

endinterface

// File: rtl/idma_axi_write_delta_counter.sv
// Up/down counter by one tracking AW bursts awaiting their B response.
// A decrement at zero is ignored so the count can never wrap.
module idma_axi_write_delta_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             down_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise step by one in the requested direction.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (!down_i) begin
                cnt_d = cnt_q + Width'(1);
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - Width'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/idma_axi_write.sv
// AXI4 write task of the iDMA transport layer: AW forwarding, W beat/strobe generation, B return.
// Build option IDMA_AXI_WRITE_MASK_INVALID_DATA_EN zeroes W data bytes whose strobe is clear.
module idma_axi_write
    import idma_axi_write_pkg::*;
#(
    parameter int unsigned StrbWidth      = DefaultStrbWidth,
    parameter int unsigned MaxOutstanding = DefaultMaxOutstanding
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  w_dp_req_t                 w_dp_req_i,
    input  logic                      w_dp_valid_i,
    output logic                      w_dp_ready_o,
    output w_dp_rsp_t                 w_dp_rsp_o,
    output logic                      w_dp_valid_o,
    input  logic                      w_dp_ready_i,
    input  aw_chan_t                  aw_req_i,
    input  logic                      aw_valid_i,
    output logic                      aw_ready_o,
    idma_axi_write_if.master          axi,
    input  logic [StrbWidth-1:0][7:0] buffer_out_i,
    input  logic [StrbWidth-1:0]      buffer_out_valid_i,
    output logic [StrbWidth-1:0]      buffer_out_ready_o,
    output logic                      w_chan_valid_o,
    output logic                      w_chan_ready_o
);

    localparam int unsigned          CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [StrbWidth-1:0] StrbOnes = {StrbWidth{1'b1}};

    logic [CntWidth-1:0]       out_cnt_s;
    logic                      out_full_s;
    logic                      aw_hs_s;
    logic                      b_hs_s;
    logic [7:0]                beat_q, beat_d;
    logic                      first_s;
    logic                      last_s;
    logic [8:0]                tail_shift_s;
    logic [StrbWidth-1:0]      mask_s;
    logic                      w_valid_s;
    logic                      w_hs_s;
    logic [StrbWidth-1:0][7:0] w_data_s;

    // AW path: blocked purely on the registered count, so a B in the same cycle cannot re-open it.
    assign out_full_s   = (out_cnt_s == CntWidth'(MaxOutstanding));
    assign axi.aw       = aw_req_i.axi.aw_chan;
    assign axi.aw_valid = aw_valid_i & ~out_full_s;
    assign aw_ready_o   = axi.aw_ready & ~out_full_s;
    assign aw_hs_s      = aw_valid_i & aw_ready_o;
    assign b_hs_s       = axi.b_valid & w_dp_ready_i;

    idma_axi_write_delta_counter #(
        .Width (CntWidth)
    ) i_out_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (1'b0),
        .en_i    (aw_hs_s ^ b_hs_s),
        .down_i  (b_hs_s),
        .q_o     (out_cnt_s)
    );

    assign first_s      = (beat_q == 8'd0);
    assign last_s       = w_dp_req_i.is_single | (beat_q == w_dp_req_i.num_beats);
    assign tail_shift_s = 9'(StrbWidth) - {1'b0, w_dp_req_i.tailer};

    // Strobe mask: trim leading bytes on the first beat, trailing bytes on a partial last beat.
    always_comb begin
        mask_s = StrbOnes;
        if (first_s) begin
            mask_s = mask_s & (StrbOnes << w_dp_req_i.offset);
        end else begin
            mask_s = mask_s;
        end
        if (last_s && (w_dp_req_i.tailer != 8'd0)) begin
            mask_s = mask_s & (StrbOnes >> tail_shift_s);
        end else begin
            mask_s = mask_s;
        end
    end

    // A beat is offered only once every strobed byte is present, so pops are all-or-nothing.
    assign w_valid_s = w_dp_valid_i & (&(buffer_out_valid_i | ~mask_s));
    assign w_hs_s    = w_valid_s & axi.w_ready;

`ifdef IDMA_AXI_WRITE_MASK_INVALID_DATA_EN
    // Zero the bytes that are not strobed.
    always_comb begin
        w_data_s = buffer_out_i;
        for (int unsigned b = 0; b < StrbWidth; b++) begin
            if (mask_s[b]) begin
                w_data_s[b] = buffer_out_i[b];
            end else begin
                w_data_s[b] = 8'h00;
            end
        end
    end
`else
    assign w_data_s = buffer_out_i;
`endif

    assign axi.w_data         = w_data_s;
    assign axi.w_strb         = mask_s;
    assign axi.w_last         = last_s;
    assign axi.w_valid        = w_valid_s;
    assign buffer_out_ready_o = w_hs_s ? mask_s : {StrbWidth{1'b0}};
    assign w_dp_ready_o       = w_hs_s & last_s;
    assign w_chan_valid_o     = w_valid_s;
    assign w_chan_ready_o     = axi.w_ready;

    assign w_dp_valid_o    = axi.b_valid;
    assign w_dp_rsp_o.resp = axi.b_resp;
    assign w_dp_rsp_o.user = axi.b_user;
    assign axi.b_ready     = w_dp_ready_i;

    assign axi.ar       = '0;
    assign axi.ar_valid = 1'b0;
    assign axi.r_ready  = 1'b0;

    // Beat position within the current burst; wraps to zero after the last beat.
    always_comb begin
        beat_d = beat_q;
        if (w_hs_s) begin
            if (last_s) begin
                beat_d = 8'd0;
            end else begin
                beat_d = beat_q + 8'd1;
            end
        end else begin
            beat_d = beat_q;
        end
    end

    // Beat register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_q <= 8'd0;
        end else begin
            beat_q <= beat_d;
        end
    end

endmodule

// File: tb/tb_idma_axi_write.sv
// Self-checking bench for idma_axi_write with StrbWidth=8, MaxOutstanding=2.
module tb_idma_axi_write;
    import idma_axi_write_pkg::*;

    localparam int unsigned SW = 8;
    localparam int unsigned MO = 2;

    logic              clk;
    logic              rst_ni;
    w_dp_req_t         w_dp_req_i;
    logic              w_dp_valid_i;
    logic              w_dp_ready_o;
    w_dp_rsp_t         w_dp_rsp_o;
    logic              w_dp_valid_o;
    logic              w_dp_ready_i;
    aw_chan_t          aw_req_i;
    logic              aw_valid_i;
    logic              aw_ready_o;
    logic [SW-1:0][7:0] buffer_out;
    logic [SW-1:0]     buffer_out_valid;
    logic [SW-1:0]     buffer_out_ready;
    logic              w_chan_valid_o;
    logic              w_chan_ready_o;

    int checks    = 0;
    int errors    = 0;
    int dp_pulses = 0;

    idma_axi_write_if #(.StrbWidth(SW)) axi_if ();

    idma_axi_write #(
        .StrbWidth      (SW),
        .MaxOutstanding (MO)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .w_dp_req_i         (w_dp_req_i),
        .w_dp_valid_i       (w_dp_valid_i),
        .w_dp_ready_o       (w_dp_ready_o),
        .w_dp_rsp_o         (w_dp_rsp_o),
        .w_dp_valid_o       (w_dp_valid_o),
        .w_dp_ready_i       (w_dp_ready_i),
        .aw_req_i           (aw_req_i),
        .aw_valid_i         (aw_valid_i),
        .aw_ready_o         (aw_ready_o),
        .axi                (axi_if),
        .buffer_out_i       (buffer_out),
        .buffer_out_valid_i (buffer_out_valid),
        .buffer_out_ready_o (buffer_out_ready),
        .w_chan_valid_o     (w_chan_valid_o),
        .w_chan_ready_o     (w_chan_ready_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Byte b of beat i is written unless it lies before the start offset (first beat)
    // or at/after the tail position of a partial last beat.
    function automatic logic [SW-1:0] exp_strb(int off, int tl, int n, int i);
        logic [SW-1:0] s;
        for (int b = 0; b < SW; b++) begin
            s[b] = !((i == 0 && b < off) || (i == n - 1 && tl != 0 && b >= tl));
        end
        return s;
    endfunction

    task automatic run_burst(input int off, input int tl, input int nb, input bit single, input bit rnd);
        int            n;
        int            i;
        int            cyc;
        logic [SW-1:0] es;
        logic          ev;
        logic          hs;
        logic          elast;
        logic [63:0]   ed;
        n   = single ? 1 : nb + 1;
        i   = 0;
        cyc = 0;
        w_dp_req_i   = '{offset: 8'(off), tailer: 8'(tl), num_beats: 8'(nb), is_single: single};
        w_dp_valid_i = 1'b1;
        while (i < n && cyc < 200) begin
            if (rnd) begin
                axi_if.w_ready   = ($urandom_range(0, 3) != 0);
                buffer_out_valid = ($urandom_range(0, 3) != 0) ? 8'hFF : 8'($urandom);
            end else begin
                axi_if.w_ready   = 1'b1;
                buffer_out_valid = 8'hFF;
            end
            @(negedge clk);
            es    = exp_strb(off, tl, n, i);
            elast = (i == n - 1);
            ev    = 1'b1;
            for (int b = 0; b < SW; b++) begin
                if (es[b] && !buffer_out_valid[b]) ev = 1'b0;
            end
            for (int b = 0; b < SW; b++) begin
`ifdef IDMA_AXI_WRITE_MASK_INVALID_DATA_EN
                ed[b*8 +: 8] = es[b] ? buffer_out[b] : 8'h00;
`else
                ed[b*8 +: 8] = buffer_out[b];
`endif
            end
            hs = ev && axi_if.w_ready;
            check("w_valid", 64'(w_chan_valid_o), 64'(ev));
            check("w_ready_obs", 64'(w_chan_ready_o), 64'(axi_if.w_ready));
            if (ev) begin
                check("w_strb", 64'(axi_if.w_strb), 64'(es));
                check("w_last", 64'(axi_if.w_last), 64'(elast));
                check("w_data", 64'(axi_if.w_data), ed);
            end
            check("pop", 64'(buffer_out_ready), hs ? 64'(es) : 64'd0);
            check("dp_ready", 64'(w_dp_ready_o), 64'(hs && elast));
            if (w_dp_ready_o === 1'b1) dp_pulses++;
            @(posedge clk);
            #1;
            if (hs) begin
                for (int b = 0; b < SW; b++) begin
                    if (es[b]) buffer_out[b] = 8'($urandom);
                end
                i++;
            end
            cyc++;
        end
        if (i < n) check("burst_timeout", 64'(i), 64'(n));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk              = 1'b0;
        rst_ni           = 1'b0;
        w_dp_req_i       = '0;
        w_dp_valid_i     = 1'b0;
        w_dp_ready_i     = 1'b0;
        aw_req_i         = '0;
        aw_valid_i       = 1'b0;
        buffer_out_valid = 8'hFF;
        for (int b = 0; b < SW; b++) buffer_out[b] = 8'($urandom);
        axi_if.aw_ready  = 1'b1;
        axi_if.w_ready   = 1'b0;
        axi_if.b_resp    = RESP_OKAY;
        axi_if.b_user    = 2'd0;
        axi_if.b_valid   = 1'b0;

        // Outputs while in reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_aw_ready_hi", 64'(aw_ready_o), 64'd1);
        axi_if.aw_ready = 1'b0;
        #1;
        check("rst_aw_ready_lo", 64'(aw_ready_o), 64'd0);
        axi_if.aw_ready = 1'b1;
        check("rst_dp_ready", 64'(w_dp_ready_o), 64'd0);
        check("rst_pop", 64'(buffer_out_ready), 64'd0);
        check("rst_w_valid", 64'(w_chan_valid_o), 64'd0);
        check("rst_b_valid", 64'(w_dp_valid_o), 64'd0);
        check("ar_valid", 64'(axi_if.ar_valid), 64'd0);
        check("r_ready", 64'(axi_if.r_ready), 64'd0);
        check("ar_payload", 64'(axi_if.ar), 64'd0);
        tick();
        rst_ni = 1'b1;
        tick();

        // Three-beat burst, then a back-to-back single beat.
        dp_pulses = 0;
        run_burst(3, 5, 2, 1'b0, 1'b0);
        check("dp_pulses_burst", 64'(dp_pulses), 64'd1);
        run_burst(2, 6, 0, 1'b1, 1'b0);
        w_dp_valid_i = 1'b0;
        tick();

        // Missing byte 7 holds the beat; once it arrives exactly 0xF8 pops.
        w_dp_req_i       = '{offset: 8'd3, tailer: 8'd0, num_beats: 8'd0, is_single: 1'b0};
        w_dp_valid_i     = 1'b1;
        axi_if.w_ready   = 1'b1;
        buffer_out_valid = 8'h78;
        @(negedge clk);
        check("partial_w_valid", 64'(w_chan_valid_o), 64'd0);
        check("partial_pop", 64'(buffer_out_ready), 64'd0);
        tick();
        buffer_out_valid = 8'hF8;
        @(negedge clk);
        check("full_w_valid", 64'(w_chan_valid_o), 64'd1);
        check("full_strb", 64'(axi_if.w_strb), 64'hF8);
        check("full_pop", 64'(buffer_out_ready), 64'hF8);
        check("full_dp_ready", 64'(w_dp_ready_o), 64'd1);
        tick();
        w_dp_valid_i     = 1'b0;
        buffer_out_valid = 8'hFF;
        axi_if.w_ready   = 1'b0;

        // Outstanding limit: two AWs fill it; a coincident B does not re-open AW that cycle.
        aw_req_i   = aw_chan_t'({$urandom, $urandom});
        aw_valid_i = 1'b1;
        @(negedge clk);
        check("aw1_ready", 64'(aw_ready_o), 64'd1);
        check("aw1_valid", 64'(axi_if.aw_valid), 64'd1);
        check("aw_payload", 64'(axi_if.aw), 64'(aw_req_i.axi.aw_chan));
        tick();
        @(negedge clk);
        check("aw2_ready", 64'(aw_ready_o), 64'd1);
        tick();
        @(negedge clk);
        check("aw3_blocked", 64'(aw_ready_o), 64'd0);
        check("aw3_valid", 64'(axi_if.aw_valid), 64'd0);
        tick();
        axi_if.b_valid = 1'b1;
        w_dp_ready_i   = 1'b1;
        @(negedge clk);
        check("aw_b_same_cycle", 64'(aw_ready_o), 64'd0);
        check("b_to_dp_valid", 64'(w_dp_valid_o), 64'd1);
        check("b_ready", 64'(axi_if.b_ready), 64'd1);
        tick();
        axi_if.b_valid = 1'b0;
        @(negedge clk);
        check("aw_reopen", 64'(aw_ready_o), 64'd1);
        check("aw_reopen_valid", 64'(axi_if.aw_valid), 64'd1);
        tick();
        aw_valid_i     = 1'b0;
        axi_if.b_valid = 1'b1;
        repeat (2) tick();
        axi_if.b_valid = 1'b0;
        w_dp_ready_i   = 1'b0;

        // SLVERR held while the backend stalls, then drained.
        aw_valid_i = 1'b1;
        tick();
        aw_valid_i     = 1'b0;
        axi_if.b_valid = 1'b1;
        axi_if.b_resp  = RESP_SLVERR;
        axi_if.b_user  = 2'd1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("b_hold_valid", 64'(w_dp_valid_o), 64'd1);
            check("b_hold_resp", 64'(w_dp_rsp_o.resp), 64'd2);
            check("b_hold_user", 64'(w_dp_rsp_o.user), 64'd1);
            check("b_hold_ready", 64'(axi_if.b_ready), 64'd0);
            tick();
        end
        w_dp_ready_i = 1'b1;
        @(negedge clk);
        check("b_release_ready", 64'(axi_if.b_ready), 64'd1);
        check("b_release_resp", 64'(w_dp_rsp_o.resp), 64'd2);
        tick();
        axi_if.b_valid = 1'b0;
        axi_if.b_resp  = RESP_OKAY;
        w_dp_ready_i   = 1'b0;

        // Count is back at zero: exactly two more AWs fit.
        aw_valid_i = 1'b1;
        @(negedge clk);
        check("post_b_aw1", 64'(aw_ready_o), 64'd1);
        tick();
        @(negedge clk);
        check("post_b_aw2", 64'(aw_ready_o), 64'd1);
        tick();
        @(negedge clk);
        check("post_b_aw3", 64'(aw_ready_o), 64'd0);
        tick();
        aw_valid_i     = 1'b0;
        axi_if.b_valid = 1'b1;
        w_dp_ready_i   = 1'b1;
        repeat (2) tick();
        axi_if.b_valid = 1'b0;
        w_dp_ready_i   = 1'b0;

        // Random back-to-back bursts with W stalls and late buffer bytes.
        dp_pulses = 0;
        for (int t = 0; t < 24; t++) begin
            run_burst($urandom_range(0, SW - 1), $urandom_range(0, SW - 1),
                      $urandom_range(0, 4), ($urandom_range(0, 3) == 0), 1'b1);
        end
        check("dp_pulses_random", 64'(dp_pulses), 64'd24);
        w_dp_valid_i = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
